// File: rtl/memd_pipe_pkg.sv
// Shared definitions for the pipelined data memory: latency-mode encoding,
// default widths and sizing helpers.
package memd_pipe_pkg;

  typedef enum logic {
    LAT_ADDR  = 1'b0,
    LAT_FIXED = 1'b1
  } lat_mode_e;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_ADDR_W    = 2;
  localparam int unsigned DEF_MAX_OUT   = 4;
  localparam int unsigned DEF_FIXED_LAT = 2;

  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Image used at reset when INIT_MEMD_CUSTOMIZED is defined.
  function automatic logic [63:0] init_word(input int unsigned idx);
    return 64'(idx) ^ 64'hA5;
  endfunction

endpackage

// File: rtl/memd_pipe_if.sv
// Request/response bundle between the load/store unit and the data memory.
interface memd_pipe_if
  import memd_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = cnt_width(DEF_MAX_OUT)
);
  logic              in_valid;
  logic              in_we;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  out_cnt;

  modport master (
    output in_valid, in_we, in_addr, in_wdata, out_ready,
    input  ready, out_valid, out_data, out_cnt
  );

  modport slave (
    input  in_valid, in_we, in_addr, in_wdata, out_ready,
    output ready, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/memd_lat_queue.sv
// In-order circular queue of {data, timer} load entries; timers count down
// to 1 and the head may leave only once its timer has reached 1.
module memd_lat_queue
  import memd_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TIM_W  = 3,
  parameter int unsigned DEPTH  = DEF_MAX_OUT,
  parameter int unsigned CNT_W  = cnt_width(DEF_MAX_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [TIM_W-1:0]  push_timer_i,
  input  logic              pop_i,
  output logic              head_ripe_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  cnt_o
);
  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [TIM_W-1:0]  timer_q [DEPTH];
  logic [TIM_W-1:0]  timer_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Free slots may count down too; a push always overwrites their timer.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      timer_d[i] = (timer_q[i] > TIM_W'(1)) ? timer_q[i] - TIM_W'(1) : timer_q[i];
    end
    if (push_i) timer_d[tail_q] = push_timer_i;
    head_d = pop_i  ? ptr_next(head_q) : head_q;
    tail_d = push_i ? ptr_next(tail_q) : tail_q;
    cnt_d  = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        timer_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      for (int unsigned i = 0; i < DEPTH; i++) timer_q[i] <= timer_d[i];
      if (push_i) data_q[tail_q] <= push_data_i;
    end
  end

  assign head_ripe_o = (cnt_q != '0) && (timer_q[head_q] == TIM_W'(1));
  assign head_data_o = data_q[head_q];
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/memd_pipe.sv
// Pipelined data memory: one load or store per cycle, up to MAX_OUT loads in
// flight, responses in program order after an address-dependent or fixed latency.
module memd_pipe
  import memd_pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_OUT   = DEF_MAX_OUT,
  parameter lat_mode_e   LAT_MODE  = LAT_ADDR,
  parameter int unsigned FIXED_LAT = DEF_FIXED_LAT
) (
  input logic        clk,
  input logic        rst,
  memd_pipe_if.slave bus
);
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned CNT_W   = cnt_width(MAX_OUT);
  localparam int unsigned FIX_W   = $clog2(FIXED_LAT + 1);
  localparam int unsigned TIM_W   = (FIX_W > ADDR_W + 1) ? FIX_W : ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ready, pop, accept, push;
  logic [TIM_W-1:0]  lat;
  logic              head_ripe;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    pop    = head_ripe && bus.out_ready;
    ready  = !rst && ((cnt < CNT_W'(MAX_OUT)) || pop);
    accept = bus.in_valid && ready;
    push   = accept && !bus.in_we;
    lat    = (LAT_MODE == LAT_FIXED) ? TIM_W'(FIXED_LAT)
                                     : TIM_W'(bus.in_addr) + TIM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef INIT_MEMD_CUSTOMIZED
        mem_q[i] <= DATA_W'(init_word(i));
`else
        mem_q[i] <= '0;
`endif
      end
    end else if (accept && bus.in_we) begin
      mem_q[bus.in_addr] <= bus.in_wdata;
    end
  end

  memd_lat_queue #(
    .DATA_W (DATA_W),
    .TIM_W  (TIM_W),
    .DEPTH  (MAX_OUT),
    .CNT_W  (CNT_W)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_data_i  (mem_q[bus.in_addr]),
    .push_timer_i (lat),
    .pop_i        (pop),
    .head_ripe_o  (head_ripe),
    .head_data_o  (head_data),
    .cnt_o        (cnt)
  );

  assign bus.ready     = ready;
  assign bus.out_valid = head_ripe;
  assign bus.out_data  = head_ripe ? head_data : '0;
  assign bus.out_cnt   = cnt;

endmodule
